// File: rtl/transmitter_if.sv
// transmitter_if: stream and status bundle between the birthday-pattern
// transmitter and its environment.
//   i_en            level enable for window counting and transmission
//   i_burst_len     patterns per window (0 = unlimited)
//   i_gap           requested idle cycles between patterns
//   o_bit_seq       serial pattern stream, idle level 1
//   o_count_for_rx  window counter, feeds the receiver's window input
//   o_tx_active     high while a pattern bit is on o_bit_seq
//   o_tx_count      patterns fully sent in the current window
//   o_tx_last       o_tx_count snapshot of the previous window
// Modport master is taken by the transmitter, slave by whoever drives it.
interface transmitter_if;
  logic       i_en;
  logic [3:0] i_burst_len;
  logic [3:0] i_gap;
  logic       o_bit_seq;
  logic [9:0] o_count_for_rx;
  logic       o_tx_active;
  logic [5:0] o_tx_count;
  logic [5:0] o_tx_last;

  modport master (
    input  i_en, i_burst_len, i_gap,
    output o_bit_seq, o_count_for_rx, o_tx_active, o_tx_count, o_tx_last
  );

  modport slave (
    output i_en, i_burst_len, i_gap,
    input  o_bit_seq, o_count_for_rx, o_tx_active, o_tx_count, o_tx_last
  );
endinterface

// File: rtl/transmitter.sv
// transmitter: sends a 9-bit birthday pattern MSB first inside a repeating
// window of WINDOW_LAST+1 enabled cycles. Patterns may only start while the
// window count is at most START_LIMIT and the burst budget is not used up.
//   i_clk  clock, all state on the rising edge
//   i_rst  asynchronous active-high reset
//   bus    transmitter_if.master (enable, burst/gap controls, serial stream,
//          window counter and pattern counters)
// Optional feature: define TX_SNAPSHOT_EN to build the o_tx_last register,
// which captures o_tx_count at the end of each window; otherwise o_tx_last
// is tied to 0.
module transmitter #(
  parameter logic [8:0]  PATTERN     = 9'b011101010,
  parameter int unsigned WINDOW_LAST = 1001,
  parameter int unsigned START_LIMIT = 990
) (
  input  logic          i_clk,
  input  logic          i_rst,
  transmitter_if.master bus
);

  localparam logic [9:0] WIN_LAST_C = WINDOW_LAST[9:0];
  localparam logic [9:0] START_C    = START_LIMIT[9:0];

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, HOLD} state_t;

  state_t     state;
  logic [9:0] win_cnt;
  logic [8:0] shreg;
  logic [3:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic       bit_seq;
  logic       tx_active;
  logic [5:0] tx_count;
  logic [3:0] eff_gap;
  logic       may_start;
  logic       count_clear;

  // A gap of 0 is stretched to 1 and a gap of 3 to 4 so the receiver FSM
  // always gets back to its start state before the next pattern.
  always_comb begin
    eff_gap = bus.i_gap;
    if (bus.i_gap == 4'd0) eff_gap = 4'd1;
    else if (bus.i_gap == 4'd3) eff_gap = 4'd4;
  end

  always_comb begin
    may_start   = (win_cnt <= START_C) &&
                  ((bus.i_burst_len == 4'd0) || ({2'b00, bus.i_burst_len} > tx_count));
    count_clear = (win_cnt == WIN_LAST_C);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_cnt <= '0;
    end else if (bus.i_en) begin
      win_cnt <= (win_cnt == WIN_LAST_C) ? '0 : win_cnt + 10'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      bit_seq   <= 1'b1;
      tx_active <= 1'b0;
      tx_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_seq   <= 1'b1;
          tx_active <= 1'b0;
          if (bus.i_en && (win_cnt <= START_C)) state <= LOAD;
        end
        LOAD: begin
          // The output is registered, so the MSB goes straight to the line
          // on the way into SHIFT and the register keeps the remaining bits.
          bit_seq   <= PATTERN[8];
          shreg     <= {PATTERN[7:0], 1'b0};
          bit_cnt   <= 4'd8;
          tx_active <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt != 4'd0) begin
            bit_seq <= shreg[8];
            shreg   <= {shreg[7:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
          end else begin
            bit_seq   <= 1'b1;
            tx_active <= 1'b0;
            if (tx_count != '1) tx_count <= tx_count + 6'd1;
            if (bus.i_en) begin
              gap_cnt <= eff_gap - 4'd1;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          bit_seq <= 1'b1;
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
          else state <= may_start ? LOAD : HOLD;
        end
        HOLD: begin
          bit_seq <= 1'b1;
          if (win_cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // End-of-window clear overrides any increment made above.
      if (count_clear) tx_count <= '0;
    end
  end

  assign bus.o_bit_seq      = bit_seq;
  assign bus.o_count_for_rx = win_cnt;
  assign bus.o_tx_active    = tx_active;
  assign bus.o_tx_count     = tx_count;

`ifdef TX_SNAPSHOT_EN
  logic [5:0] tx_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tx_last <= '0;
    else if (count_clear) tx_last <= tx_count;
  end

  assign bus.o_tx_last = tx_last;
`else
  assign bus.o_tx_last = '0;
`endif

endmodule

// File: tb/tb_transmitter.sv
module tb_transmitter;
  logic clk = 1'b0;
  logic rst;

  transmitter_if bus_if ();

  transmitter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        exp_q[$];
  logic [9:0]  start_q[$];
  logic        prev_active = 1'b0;
  logic [8:0]  pat = 9'b011101010;
`ifdef TX_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every bit on the line while o_tx_active is high
  // must match the next expected bit; window count at each start is logged.
  always @(negedge clk) begin
    if (bus_if.o_tx_active === 1'b1) begin
      if (!prev_active) start_q.push_back(bus_if.o_count_for_rx);
      chk("bit_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("bit_value", 32'(bus_if.o_bit_seq), 32'(exp_q.pop_front()));
    end
    prev_active = bus_if.o_tx_active;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_patterns(input int unsigned n);
    for (int unsigned p = 0; p < n; p++)
      for (int b = 8; b >= 0; b--) exp_q.push_back(pat[b]);
  endtask

  task automatic do_reset(input logic [3:0] burst, input logic [3:0] gap);
    rst = 1'b1;
    bus_if.i_en = 1'b0;
    bus_if.i_burst_len = burst;
    bus_if.i_gap = gap;
    step(2);
    exp_q.delete();
    start_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input logic [9:0] target, input int unsigned limit);
    int unsigned n = 0;
    while (bus_if.o_count_for_rx !== target && n < limit) begin
      step(1);
      n++;
    end
    chk("wait_cnt", 32'(bus_if.o_count_for_rx), 32'(target));
  endtask

  task automatic chk_starts(input string tag, input int unsigned first,
                            input int unsigned period, input int unsigned n);
    chk({tag, "_num"}, 32'(start_q.size()), n);
    for (int unsigned k = 0; k < n && k < 32'(start_q.size()); k++)
      chk(tag, 32'(start_q[k]), first + period * k);
  endtask

  initial begin
    // Reset values while reset is held
    rst = 1'b1;
    bus_if.i_en = 1'b0;
    bus_if.i_burst_len = 4'd1;
    bus_if.i_gap = 4'd2;
    step(2);
    chk("rst_bit_seq", 32'(bus_if.o_bit_seq), 32'd1);
    chk("rst_count", 32'(bus_if.o_count_for_rx), 32'd0);
    chk("rst_active", 32'(bus_if.o_tx_active), 32'd0);
    chk("rst_tx_count", 32'(bus_if.o_tx_count), 32'd0);
    chk("rst_tx_last", 32'(bus_if.o_tx_last), 32'd0);

    // Single burst, gap 2: LOAD on first edge, bits on cycles 2..10
    rst = 1'b0;
    bus_if.i_en = 1'b1;
    push_patterns(1);
    step(1);
    chk("t1_load_line", 32'(bus_if.o_bit_seq), 32'd1);
    chk("t1_load_active", 32'(bus_if.o_tx_active), 32'd0);
    chk("t1_load_count", 32'(bus_if.o_count_for_rx), 32'd1);
    step(1);
    chk("t1_first_active", 32'(bus_if.o_tx_active), 32'd1);
    step(8);
    chk("t1_cnt_before_end", 32'(bus_if.o_tx_count), 32'd0);
    step(1);
    chk("t1_cnt_c11", 32'(bus_if.o_tx_count), 32'd1);
    chk("t1_active_c11", 32'(bus_if.o_tx_active), 32'd0);
    chk("t1_line_c11", 32'(bus_if.o_bit_seq), 32'd1);
    step(30);
    chk("t1_line_hold", 32'(bus_if.o_bit_seq), 32'd1);
    chk("t1_cnt_hold", 32'(bus_if.o_tx_count), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    chk_starts("t1_start", 2, 11, 1);

    // Burst of 5, gap 1, then end-of-window clear and snapshot
    do_reset(4'd5, 4'd1);
    bus_if.i_en = 1'b1;
    push_patterns(5);
    wait_cnt(10'd1000, 1100);
    chk("t2_cnt_1000", 32'(bus_if.o_tx_count), 32'd5);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
    chk_starts("t2_start", 2, 11, 5);
    step(1);
    chk("t2_win_1001", 32'(bus_if.o_count_for_rx), 32'd1001);
    chk("t2_cnt_1001", 32'(bus_if.o_tx_count), 32'd5);
    step(1);
    chk("t2_cnt_clear", 32'(bus_if.o_tx_count), 32'd0);
    chk("t2_win_wrap", 32'(bus_if.o_count_for_rx), 32'd0);
    chk("t2_tx_last", 32'(bus_if.o_tx_last), SNAP ? 32'd5 : 32'd0);

    // Effective gap mapping: 3 -> 4, 0 -> 1, 5 -> 5
    do_reset(4'd3, 4'd3);
    bus_if.i_en = 1'b1;
    push_patterns(3);
    step(60);
    chk_starts("gap3_start", 2, 14, 3);
    chk("gap3_q_empty", 32'(exp_q.size()), 32'd0);
    chk("gap3_tx_count", 32'(bus_if.o_tx_count), 32'd3);

    do_reset(4'd2, 4'd0);
    bus_if.i_en = 1'b1;
    push_patterns(2);
    step(40);
    chk_starts("gap0_start", 2, 11, 2);
    chk("gap0_q_empty", 32'(exp_q.size()), 32'd0);

    do_reset(4'd2, 4'd5);
    bus_if.i_en = 1'b1;
    push_patterns(2);
    step(40);
    chk_starts("gap5_start", 2, 15, 2);
    chk("gap5_q_empty", 32'(exp_q.size()), 32'd0);

    // Unlimited burst: 91 patterns in the first window, count saturates
    do_reset(4'd0, 4'd1);
    bus_if.i_en = 1'b1;
    push_patterns(91);
    wait_cnt(10'd1001, 1100);
    chk("t4_saturated", 32'(bus_if.o_tx_count), 32'd63);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
    chk_starts("t4_start", 2, 11, 91);
    step(1);
    chk("t4_cnt_clear", 32'(bus_if.o_tx_count), 32'd0);
    chk("t4_tx_last", 32'(bus_if.o_tx_last), SNAP ? 32'd63 : 32'd0);

    // Enable dropped on the 4th bit: pattern completes, window frozen
    do_reset(4'd0, 4'd1);
    bus_if.i_en = 1'b1;
    push_patterns(1);
    step(5);
    chk("t5_active_b4", 32'(bus_if.o_tx_active), 32'd1);
    bus_if.i_en = 1'b0;
    step(5);
    chk("t5_win_frozen", 32'(bus_if.o_count_for_rx), 32'd5);
    chk("t5_active_b9", 32'(bus_if.o_tx_active), 32'd1);
    step(1);
    chk("t5_active_done", 32'(bus_if.o_tx_active), 32'd0);
    chk("t5_line_done", 32'(bus_if.o_bit_seq), 32'd1);
    chk("t5_tx_count", 32'(bus_if.o_tx_count), 32'd1);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
    step(10);
    chk("t5_win_still", 32'(bus_if.o_count_for_rx), 32'd5);
    chk("t5_idle_active", 32'(bus_if.o_tx_active), 32'd0);
    push_patterns(1);
    bus_if.i_en = 1'b1;
    step(11);
    chk("t5_restart_num", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) chk("t5_restart_at", 32'(start_q[1]), 32'd7);
    chk("t5_restart_q", 32'(exp_q.size()), 32'd0);
    chk("t5_restart_cnt", 32'(bus_if.o_tx_count), 32'd2);

    // Reset on the 5th bit (a 0): line returns to 1 with no clock edge
    do_reset(4'd0, 4'd1);
    bus_if.i_en = 1'b1;
    push_patterns(1);
    step(6);
    chk("t6_bit5_line", 32'(bus_if.o_bit_seq), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_abort_line", 32'(bus_if.o_bit_seq), 32'd1);
    chk("t6_abort_active", 32'(bus_if.o_tx_active), 32'd0);
    chk("t6_abort_cnt", 32'(bus_if.o_tx_count), 32'd0);
    chk("t6_abort_win", 32'(bus_if.o_count_for_rx), 32'd0);
    chk("t6_bits_left", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    step(3);
    chk("t6_q_quiet", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
